// File: rtl/draw_pkg.sv
// Shared drawing constants, blitter state encoding and the signed
// screen-coordinate type used by the layer and sprite engines.
package draw_pkg;
    localparam int COLOR_WIDTH   = 12;
    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 240;
    localparam int COORD_WIDTH   = 11;
    localparam logic [COLOR_WIDTH-1:0] TRANSPARENT = 12'h000;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // One extra bit so pos + offset never overflows into the sign.
    typedef logic signed [COORD_WIDTH:0] coord_t;
endpackage

// File: rtl/blit_addr_gen.sv
// Walks the sprite x-fastest, maps flips onto sprite addresses and turns the
// screen position into a VRAM address plus an on-screen flag.
module blit_addr_gen #(
    parameter int SCREEN_WIDTH      = draw_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT     = draw_pkg::SCREEN_HEIGHT,
    parameter int SPRITEBUF_A_WIDTH = 13,
    parameter int VRAM_A_WIDTH      = 17,
    parameter int COORD_WIDTH       = draw_pkg::COORD_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          load,
    input  logic                          step,
    input  logic [SPRITEBUF_A_WIDTH-1:0]  sprite_base,
    input  logic [9:0]                    sprite_w,
    input  logic [9:0]                    sprite_h,
    input  logic signed [COORD_WIDTH-1:0] pos_x,
    input  logic signed [COORD_WIDTH-1:0] pos_y,
    input  logic                          flip_x,
    input  logic                          flip_y,
    output logic                          last,
    output logic [SPRITEBUF_A_WIDTH-1:0]  sprite_addr,
    output logic                          iss_vld,
    output logic                          iss_inb,
    output logic [VRAM_A_WIDTH-1:0]       iss_vaddr
);
    localparam int SUM_W = (SPRITEBUF_A_WIDTH > 20 ? SPRITEBUF_A_WIDTH : 20) + 1;
    localparam logic signed [COORD_WIDTH:0] SW_C = (COORD_WIDTH+1)'(SCREEN_WIDTH);
    localparam logic signed [COORD_WIDTH:0] SH_C = (COORD_WIDTH+1)'(SCREEN_HEIGHT);

    logic [SPRITEBUF_A_WIDTH-1:0]  base_q;
    logic [9:0]                    w_q, h_q, x_q, y_q, sx, sy;
    logic signed [COORD_WIDTH-1:0] px_q, py_q;
    logic                          fx_q, fy_q, in_bounds;
    logic [19:0]                   prod;
    logic [SUM_W-1:0]              saddr;
    logic signed [COORD_WIDTH:0]   scr_x, scr_y;
    logic [VRAM_A_WIDTH-1:0]       vaddr;

    always_comb begin
        sx    = fx_q ? (w_q - 10'd1 - x_q) : x_q;
        sy    = fy_q ? (h_q - 10'd1 - y_q) : y_q;
        prod  = 20'(sy) * 20'(w_q);
        saddr = SUM_W'(base_q) + SUM_W'(prod) + SUM_W'(sx);
        scr_x = {px_q[COORD_WIDTH-1], px_q} + (COORD_WIDTH+1)'(x_q);
        scr_y = {py_q[COORD_WIDTH-1], py_q} + (COORD_WIDTH+1)'(y_q);
        in_bounds = !scr_x[COORD_WIDTH] && (scr_x < SW_C) &&
                    !scr_y[COORD_WIDTH] && (scr_y < SH_C);
        // Only meaningful when in_bounds; sign extension keeps the wrap consistent.
        vaddr = VRAM_A_WIDTH'(scr_y) * VRAM_A_WIDTH'(SCREEN_WIDTH) + VRAM_A_WIDTH'(scr_x);
        last  = (x_q == w_q - 10'd1) && (y_q == h_q - 10'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            w_q         <= '0;
            h_q         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            fx_q        <= 1'b0;
            fy_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            sprite_addr <= '0;
            iss_vld     <= 1'b0;
            iss_inb     <= 1'b0;
            iss_vaddr   <= '0;
        end else if (ena) begin
            iss_vld <= step;
            if (load) begin
                base_q <= sprite_base;
                w_q    <= sprite_w;
                h_q    <= sprite_h;
                px_q   <= pos_x;
                py_q   <= pos_y;
                fx_q   <= flip_x;
                fy_q   <= flip_y;
                x_q    <= '0;
                y_q    <= '0;
            end else if (step) begin
                sprite_addr <= saddr[SPRITEBUF_A_WIDTH-1:0];
                iss_inb     <= in_bounds;
                iss_vaddr   <= vaddr;
                if (x_q == w_q - 10'd1) begin
                    x_q <= '0;
                    y_q <= y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
        end
    end
endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite into the frame buffer with flip, clipping and colour key;
// three-stage issue/read/write pipeline behind a start/busy/done handshake.
module sprite_blitter #(
    parameter int SCREEN_WIDTH      = draw_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT     = draw_pkg::SCREEN_HEIGHT,
    parameter int SPRITEBUF_A_WIDTH = 13,
    parameter int VRAM_A_WIDTH      = 17,
    parameter int COLOR_WIDTH       = draw_pkg::COLOR_WIDTH,
    parameter logic [COLOR_WIDTH-1:0] TRANSPARENT = draw_pkg::TRANSPARENT,
    parameter int COORD_WIDTH       = draw_pkg::COORD_WIDTH
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          start,
    input  logic [SPRITEBUF_A_WIDTH-1:0]  sprite_base,
    input  logic [9:0]                    sprite_w,
    input  logic [9:0]                    sprite_h,
    input  logic signed [COORD_WIDTH-1:0] pos_x,
    input  logic signed [COORD_WIDTH-1:0] pos_y,
    input  logic                          flip_x,
    input  logic                          flip_y,
    output logic                          busy,
    output logic                          done,
    output logic [SPRITEBUF_A_WIDTH-1:0]  sprite_addr,
    input  logic [COLOR_WIDTH-1:0]        sprite_data,
    output logic [VRAM_A_WIDTH-1:0]       vram_addr,
    output logic [COLOR_WIDTH-1:0]        vram_data,
    output logic                          vram_we
);
    import draw_pkg::state_t, draw_pkg::IDLE, draw_pkg::RUN, draw_pkg::DRAIN, draw_pkg::DONE;

    state_t                  state_q, state_d;
    logic                    drain_q, load, step, last;
    logic                    iss_vld, iss_inb, s1_vld, s1_inb;
    logic [VRAM_A_WIDTH-1:0] iss_vaddr, s1_vaddr;
    logic                    we_q, busy_q, done_q;

    blit_addr_gen #(
        .SCREEN_WIDTH      (SCREEN_WIDTH),
        .SCREEN_HEIGHT     (SCREEN_HEIGHT),
        .SPRITEBUF_A_WIDTH (SPRITEBUF_A_WIDTH),
        .VRAM_A_WIDTH      (VRAM_A_WIDTH),
        .COORD_WIDTH       (COORD_WIDTH)
    ) u_addr_gen (
        .clk         (CLK),
        .rst_n       (rst_n),
        .ena         (ena),
        .load        (load),
        .step        (step),
        .sprite_base (sprite_base),
        .sprite_w    (sprite_w),
        .sprite_h    (sprite_h),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip_x      (flip_x),
        .flip_y      (flip_y),
        .last        (last),
        .sprite_addr (sprite_addr),
        .iss_vld     (iss_vld),
        .iss_inb     (iss_inb),
        .iss_vaddr   (iss_vaddr)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                load    = 1'b1;
                state_d = (sprite_w == 10'd0 || sprite_h == 10'd0) ? DONE : RUN;
            end
            RUN: begin
                step = 1'b1;
                if (last) state_d = DRAIN;
            end
            DRAIN: if (drain_q) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s1_vld    <= 1'b0;
            s1_inb    <= 1'b0;
            s1_vaddr  <= '0;
            we_q      <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else if (ena) begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) && !drain_q;
            if (load)                 busy_q <= 1'b1;
            else if (state_q == DONE) busy_q <= 1'b0;
            done_q    <= (state_q == DONE);
            // Stage 1 travels alongside the outstanding sprite read.
            s1_vld    <= iss_vld;
            s1_inb    <= iss_inb;
            s1_vaddr  <= iss_vaddr;
            we_q      <= s1_vld && s1_inb && (sprite_data != TRANSPARENT);
            vram_data <= sprite_data;
            vram_addr <= s1_vaddr;
        end
    end

    // Strobes held through a frozen cycle must not repeat a write or a completion.
    assign vram_we = we_q && ena;
    assign done    = done_q && ena;
    assign busy    = busy_q;
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: vector table of blits plus hand sequences
// for ena stalls, ignored starts, zero-size requests and mid-blit reset.
module tb_sprite_blitter;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ena = 1'b1;
    logic               start = 1'b0;
    logic [12:0]        sprite_base = '0;
    logic [9:0]         sprite_w = '0, sprite_h = '0;
    logic signed [10:0] pos_x = '0, pos_y = '0;
    logic               flip_x = 1'b0, flip_y = 1'b0;
    logic               busy, done, vram_we;
    logic [12:0]        sprite_addr;
    logic [11:0]        sprite_data = '0;
    logic [16:0]        vram_addr;
    logic [11:0]        vram_data;
    logic [11:0]        rom [0:8191];

    sprite_blitter dut (
        .CLK(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .sprite_base(sprite_base), .sprite_w(sprite_w), .sprite_h(sprite_h),
        .pos_x(pos_x), .pos_y(pos_y), .flip_x(flip_x), .flip_y(flip_y),
        .busy(busy), .done(done), .sprite_addr(sprite_addr),
        .sprite_data(sprite_data), .vram_addr(vram_addr),
        .vram_data(vram_data), .vram_we(vram_we)
    );

    always #5 clk = ~clk;

    // Synchronous sprite memory sharing the global clock enable.
    always @(posedge clk) if (ena) sprite_data <= rom[sprite_addr];

    typedef struct { int a; int d; } wr_t;
    typedef struct {
        int base; int w; int h; int px; int py; bit fx; bit fy;
        int n_wr; int first_va; int first_d; int lat; int first_sa; int busy_n;
    } vec_t;

    int   checks = 0, failures = 0, cyc = 0;
    bit   mon = 1'b0;
    int   busy_n, done_n, rise_cyc, we_cyc, sa_first;
    wr_t  got_q[$], exp_q[$];
    wr_t  wtmp;
    vec_t vt[8];

    always @(negedge clk) begin
        cyc++;
        if (mon) begin
            if (vram_we) begin
                if (we_cyc < 0) we_cyc = cyc;
                wtmp.a = int'(vram_addr);
                wtmp.d = int'(vram_data);
                got_q.push_back(wtmp);
            end
            if (busy) begin
                if (busy_n == 0) rise_cyc = cyc;
                if (busy_n == 1) sa_first = int'(sprite_addr);
                busy_n++;
            end
            if (done) done_n++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mon_clear();
        got_q.delete();
        busy_n = 0; done_n = 0; we_cyc = -1; rise_cyc = -1; sa_first = -1;
    endtask

    task automatic build_exp(input vec_t v);
        exp_q.delete();
        for (int y = 0; y < v.h; y++) begin
            for (int x = 0; x < v.w; x++) begin
                int sx, sy, sa, scx, scy;
                wr_t e;
                sx  = v.fx ? v.w - 1 - x : x;
                sy  = v.fy ? v.h - 1 - y : y;
                sa  = (v.base + sy * v.w + sx) % 8192;
                scx = v.px + x;
                scy = v.py + y;
                if (scx >= 0 && scx < 320 && scy >= 0 && scy < 240 && rom[sa] != 12'h000) begin
                    e.a = scy * 320 + scx;
                    e.d = int'(rom[sa]);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic chk_seq(input string nm);
        bit same;
        same = (got_q.size() == exp_q.size());
        if (same)
            foreach (got_q[i])
                if (got_q[i].a != exp_q[i].a || got_q[i].d != exp_q[i].d) same = 1'b0;
        chk(nm, int'(same), 1);
    endtask

    task automatic drive_req(input vec_t v);
        sprite_base = 13'(v.base);
        sprite_w    = 10'(v.w);
        sprite_h    = 10'(v.h);
        pos_x       = 11'(v.px);
        pos_y       = 11'(v.py);
        flip_x      = v.fx;
        flip_y      = v.fy;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_n == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_n == 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        vec_t vz;
        int   sa_before;
        for (int i = 0; i < 8192; i++) rom[i] = {1'b1, 11'(i)};
        for (int k = 0; k < 4; k++) rom[12'h300 + 2 * k] = 12'h000;

        //        base   w h  px   py  fx fy  n  first_va first_d lat first_sa busy
        vt[0] = '{'h100, 4,2, 10,   5, 0, 0,  8, 1610,   'h900,  3, 'h100, 11};
        vt[1] = '{'h100, 4,2, 10,   5, 1, 0,  8, 1610,   'h903,  3, 'h103, 11};
        vt[2] = '{'h100, 4,2, 10,   5, 0, 1,  8, 1610,   'h904,  3, 'h104, 11};
        vt[3] = '{'h200, 4,4, -2,  -1, 0, 0,  6, 0,      'hA06,  9, 'h200, 19};
        vt[4] = '{'h300, 8,1,  0,   0, 0, 0,  4, 1,      'hB01,  4, 'h300, 11};
        vt[5] = '{'h100, 4,2, -20,  0, 0, 0,  0, -1,     -1,    -1, 'h100, 11};
        vt[6] = '{'h500, 4,4, 318, 238,0, 0,  4, 76478,  'hD00,  3, 'h500, 19};
        vt[7] = '{'h200, 4,4, -2,  -1, 1, 1,  6, 0,      'hA09,  9, 'h20F, 19};

        // Reset state
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(vram_we), 0);
        chk("rst_saddr", int'(sprite_addr), 0);
        chk("rst_vaddr", int'(vram_addr), 0);
        chk("rst_vdata", int'(vram_data), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vt[i]) begin
            mon_clear();
            build_exp(vt[i]);
            mon = 1'b1;
            @(posedge clk); #1;
            drive_req(vt[i]);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(500);
            repeat (5) @(posedge clk);
            #1;
            mon = 1'b0;
            chk($sformatf("v%0d_nwr", i), got_q.size(), vt[i].n_wr);
            chk($sformatf("v%0d_first_sa", i), sa_first, vt[i].first_sa);
            chk($sformatf("v%0d_busy", i), busy_n, vt[i].busy_n);
            chk($sformatf("v%0d_done", i), done_n, 1);
            if (vt[i].n_wr > 0 && got_q.size() > 0) begin
                chk($sformatf("v%0d_first_va", i), got_q[0].a, vt[i].first_va);
                chk($sformatf("v%0d_first_d", i), got_q[0].d, vt[i].first_d);
                chk($sformatf("v%0d_lat", i), we_cyc - rise_cyc, vt[i].lat);
            end
            chk_seq($sformatf("v%0d_seq", i));
        end

        // ena toggled every cycle: identical writes, none duplicated
        vz = '{'h400, 4,4, 0,0, 0,0, 16, 0, 'hC00, 0, 'h400, 0};
        mon_clear();
        build_exp(vz);
        mon = 1'b1;
        @(posedge clk); #1;
        drive_req(vz);
        start = 1'b1;
        ena = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ena = 1'b0;
        begin
            int n;
            n = 0;
            while (done_n == 0 && n < 500) begin
                @(posedge clk); #1;
                ena = ~ena;
                n++;
            end
            if (done_n == 0) chk("ena_done_timeout", 0, 1);
        end
        repeat (6) begin @(posedge clk); #1; ena = ~ena; end
        ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon = 1'b0;
        chk("ena_nwr", got_q.size(), 16);
        chk("ena_done", done_n, 1);
        chk_seq("ena_seq");

        // Start while busy and in DONE is ignored; inputs are not resampled
        mon_clear();
        build_exp(vt[0]);
        mon = 1'b1;
        @(posedge clk); #1;
        drive_req(vt[0]);
        start = 1'b1;
        @(posedge clk); #1;
        drive_req(vt[4]);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        mon = 1'b0;
        chk("ign_busy", busy_n, 11);
        chk("ign_done", done_n, 1);
        chk_seq("ign_seq");

        // Zero-width request: straight to DONE, no reads or writes
        mon_clear();
        mon = 1'b1;
        sa_before = int'(sprite_addr);
        @(posedge clk); #1;
        vz = '{'h123, 0,3, 0,0, 0,0, 0, 0, 0, 0, 0, 0};
        drive_req(vz);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zw_busy", int'(busy), 1);
        chk("zw_done_early", int'(done), 0);
        @(negedge clk);
        chk("zw_done", int'(done), 1);
        chk("zw_busy_fall", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        mon = 1'b0;
        chk("zw_nwr", got_q.size(), 0);
        chk("zw_done_n", done_n, 1);
        chk("zw_noread", int'(sprite_addr), sa_before);

        // Reset mid-blit aborts at once, no done
        @(posedge clk); #1;
        drive_req(vt[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_we_before", int'(vram_we), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", int'(busy), 0);
        chk("mid_we", int'(vram_we), 0);
        chk("mid_saddr", int'(sprite_addr), 0);
        chk("mid_vaddr", int'(vram_addr), 0);
        chk("mid_vdata", int'(vram_data), 0);
        chk("mid_done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_clear();
        mon = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        mon = 1'b0;
        chk("mid_no_done", done_n, 0);
        chk("mid_no_wr", got_q.size(), 0);
        chk("mid_idle", busy_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised successor to the per-layer drawing engine.
- Copies one rectangular sprite from sprite ROM/buffer into the VRAM frame buffer at a signed screen position.
- Adds a start/busy/done handshake, runtime sprite size and base, H/V flip, screen-edge clipping, and colour-key transparency.
- Sits between the scene/layer sequencer (which issues one blit per object) and the dual-port VRAM write port.

Parameters:
- SCREEN_WIDTH, 320, frame buffer width in pixels; also the row stride.
- SCREEN_HEIGHT, 240, frame buffer height in pixels.
- SPRITEBUF_A_WIDTH, 13, sprite buffer address width.
- VRAM_A_WIDTH, 17, VRAM address width.
- COLOR_WIDTH, 12, pixel data width.
- TRANSPARENT, 12'h000, colour key; matching pixels are not written.
- COORD_WIDTH, 11, signed screen-position width.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global advance enable; low freezes all state.
- start  in  1  one-cycle request; sampled only in IDLE.
- sprite_base  in  SPRITEBUF_A_WIDTH  first sprite word.
- sprite_w  in  10  sprite width in pixels.
- sprite_h  in  10  sprite height in pixels.
- pos_x  in  COORD_WIDTH  signed left edge.
- pos_y  in  COORD_WIDTH  signed top edge.
- flip_x  in  1  mirror horizontally.
- flip_y  in  1  mirror vertically.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- sprite_addr  out  SPRITEBUF_A_WIDTH  sprite read address.
- sprite_data  in  COLOR_WIDTH  read data, valid 1 cycle after sprite_addr.
- vram_addr  out  VRAM_A_WIDTH  write address.
- vram_data  out  COLOR_WIDTH  write data.
- vram_we  out  1  write strobe.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; counters 0; busy=0, done=0, vram_we=0, sprite_addr=0, vram_addr=0, vram_data=0; pipeline valid bits cleared.
- ena low: all registers hold. vram_we is combinationally gated to 0 so a frozen write is not repeated.
- State IDLE: on start, latch all request inputs and zero x/y.
  - sprite_w==0 or sprite_h==0 -> DONE.
  - Otherwise -> RUN; busy rises the next cycle.
- State RUN: one pixel per ena cycle, x fastest. After x=w-1,y=h-1 -> DRAIN.
- State DRAIN: 2 ena cycles to empty the pipeline, then -> DONE.
- State DONE: done=1 for one cycle, busy=0 -> IDLE. A start arriving in DONE is ignored.
- Stage 0 (issue):
  - sx = flip_x ? w-1-x : x; sy = flip_y ? h-1-y : y.
  - sprite_addr <= base + sy*w + sx, truncated to SPRITEBUF_A_WIDTH.
  - Screen coordinates: scr_x = pos_x + x, scr_y = pos_y + y, computed at COORD_WIDTH+1 bits signed.
  - in_bounds = 0<=scr_x<SCREEN_WIDTH && 0<=scr_y<SCREEN_HEIGHT.
- Stage 1: carry valid, in_bounds, and SCREEN_WIDTH*scr_y+scr_x (truncated to VRAM_A_WIDTH) alongside the outstanding read.
- Stage 2:
  - vram_we <= valid && in_bounds && sprite_data!=TRANSPARENT.
  - vram_data <= sprite_data; vram_addr <= stage-1 address.
- Latency: pixel issued at ena-cycle t appears on the VRAM port at t+2.
- Clipped or transparent pixels consume a cycle but produce no write.
- Fully off-screen sprite still runs w*h+2 cycles and produces zero writes.
- Start while busy is ignored; request inputs are not resampled.
- Reset asserted mid-blit aborts immediately; no done pulse.

Decomposition:
- Shared package draw_pkg holds:
  - COLOR_WIDTH, SCREEN_WIDTH, SCREEN_HEIGHT, TRANSPARENT;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the signed coordinate typedef.
- One natural sub-module: blit_addr_gen (x/y counters, flip mapping, sprite and VRAM address arithmetic, in_bounds). The top keeps the FSM and the stage-2 write logic.

Test Plan:
- 4x2 sprite at (10,5), no flip, all pixels opaque -> 8 writes, first to vram_addr 5*320+10=1610; first vram_we 2 cycles after first sprite_addr; done pulses once; busy high for 8+2 cycles plus the DONE cycle.
- Same sprite with flip_x=1 -> first sprite_addr=base+3 while vram_addr=1610; with flip_y=1 -> first sprite_addr=base+4.
- Sprite at (-2,-1), 4x4 -> only pixels with x>=2,y>=1 written (6 writes); the first write goes to vram_addr 0.
- Sprite data pattern with TRANSPARENT at every other pixel of an 8x1 sprite -> exactly 4 vram_we pulses at the odd positions.
- ena toggled 1/0 every cycle during a 4x4 blit -> same 16 addresses and data as with ena=1; no duplicated vram_we.
- sprite_w=0 -> done one cycle after the DONE transition with zero reads/writes. Separately: rst_n pulsed low mid-blit -> all outputs 0 immediately, returns to IDLE, no done.
